dma_byte_writer: RTL and testbench

- Write-side counterpart of the DMA read/serialize path.
- Accepts a byte stream, packs it little-endian into 32-bit words, and buffers them in a small FIFO.
- Issues one DMA write per word to the AHB-Lite master, starting at an RCC-programmed address and incrementing by 4.
- Sits between the byte-stream source and the DMA master's write request port.

---
 rtl/dma_byte_writer_pkg.sv | 20 ++
 rtl/dma_byte_writer_word_fifo.sv | 51 +++++
 rtl/dma_byte_writer.sv | 181 ++++++++++++++++++
 tb/tb_dma_byte_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_byte_writer_pkg.sv
// Shared types and constants for the DMA byte writer: FSM state encoding,
// word geometry and the address-step helper.
package dma_byte_writer_pkg;

  typedef enum logic [1:0] {
    Writer_IDLE,
    Writer_RUN,
    Writer_WAIT,
    Writer_DONE
  } Writer_state;

  localparam int          WORD_BYTES = 4;
  localparam logic [1:0]  LANE_LAST  = 2'(WORD_BYTES - 1);

  // Addresses wrap modulo 2^32 and are never realigned.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/dma_byte_writer_word_fifo.sv
// Show-ahead synchronous FIFO of packed 32-bit words between the byte packer
// and the DMA write FSM.
module word_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic              w_do_push;
  logic              w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign rdata = r_mem[r_rptr[AW-1:0]];

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= wdata;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/dma_byte_writer.sv
// Packs a byte stream little-endian into words and issues one DMA write per word.
// Optional DMA_BYTE_WRITER_CHECKSUM_EN adds o_checksum (sum of completed words).
module dma_byte_writer
  import dma_byte_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic [15:0]      i_RCC_DMA_ADDR_HIGH,
  input  logic [15:0]      i_RCC_DMA_ADDR_LOW,
  input  logic [LEN_W-1:0] i_RCC_DMA_LEN,
  input  logic             Write_Request,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  output logic             DMA_WRITE,
  output logic [31:0]      DMA_WRITE_addr,
  output logic [31:0]      DMA_WRITE_data,
  input  logic             i_DMA_WRITE_done,
  output logic             o_busy,
  output logic             o_done
`ifdef DMA_BYTE_WRITER_CHECKSUM_EN
  ,
  output logic [31:0]      o_checksum
`endif
);

  Writer_state      r_state;
  Writer_state      w_next_state;

  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_words_packed;
  logic [1:0]       r_lane;
  logic [23:0]      r_word;

  logic             w_start;
  logic             w_active;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_wait_done;
  logic [31:0]      w_push_data;
  logic [31:0]      w_fifo_rdata;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  assign w_start     = (r_state == Writer_IDLE) && Write_Request;
  assign w_active    = (r_state == Writer_RUN) || (r_state == Writer_WAIT);
  assign w_accept    = i_byte_valid && o_byte_ready;
  assign w_push      = w_accept && (r_lane == LANE_LAST);
  assign w_pop       = (r_state == Writer_RUN) && !w_fifo_empty;
  assign w_wait_done = (r_state == Writer_WAIT) && i_DMA_WRITE_done;
  assign w_push_data = {i_byte, r_word};

  word_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (32)
  ) u_word_fifo (
    .CLK    (CLK),
    .RESETn (RESETn),
    .push   (w_push),
    .pop    (w_pop),
    .wdata  (w_push_data),
    .rdata  (w_fifo_rdata),
    .full   (w_fifo_full),
    .empty  (w_fifo_empty)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= Writer_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    DMA_WRITE      = 1'b0;
    DMA_WRITE_data = r_data;
    case (r_state)
      Writer_IDLE: begin
        if (Write_Request) begin
          w_next_state = (i_RCC_DMA_LEN == '0) ? Writer_DONE : Writer_RUN;
        end
      end
      Writer_RUN: begin
        // The head word is driven straight out so data is valid in the pulse cycle.
        if (!w_fifo_empty) begin
          DMA_WRITE      = 1'b1;
          DMA_WRITE_data = w_fifo_rdata;
          w_next_state   = Writer_WAIT;
        end
      end
      Writer_WAIT: begin
        if (i_DMA_WRITE_done) begin
          w_next_state = (r_remaining == LEN_W'(1)) ? Writer_DONE : Writer_RUN;
        end
      end
      Writer_DONE: begin
        w_next_state = Writer_IDLE;
      end
      default: begin
        w_next_state = Writer_IDLE;
      end
    endcase
  end

  assign o_busy         = (r_state != Writer_IDLE);
  assign o_done         = (r_state == Writer_DONE);
  assign DMA_WRITE_addr = r_addr;

  // A lane-3 byte needs a free FIFO slot; lanes 0-2 only fill the holding register.
  assign o_byte_ready = w_active
                     && (r_words_packed < r_len)
                     && !(w_fifo_full && (r_lane == LANE_LAST));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_addr      <= '0;
      r_data      <= '0;
      r_remaining <= '0;
      r_len       <= '0;
    end else begin
      if (w_start) begin
        r_addr      <= {i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW};
        r_remaining <= i_RCC_DMA_LEN;
        r_len       <= i_RCC_DMA_LEN;
      end
      if (w_pop) begin
        r_data <= w_fifo_rdata;
      end
      if (w_wait_done) begin
        r_addr      <= next_word_addr(r_addr);
        r_remaining <= r_remaining - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_lane         <= '0;
      r_word         <= '0;
      r_words_packed <= '0;
    end else if (w_start) begin
      r_lane         <= '0;
      r_word         <= '0;
      r_words_packed <= '0;
    end else if (w_accept) begin
      case (r_lane)
        2'd0:    r_word[7:0]   <= i_byte;
        2'd1:    r_word[15:8]  <= i_byte;
        2'd2:    r_word[23:16] <= i_byte;
        default: r_words_packed <= r_words_packed + LEN_W'(1);
      endcase
      r_lane <= r_lane + 2'd1;
    end
  end

`ifdef DMA_BYTE_WRITER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_checksum <= '0;
    end else if (w_start) begin
      r_checksum <= '0;
    end else if (w_wait_done) begin
      r_checksum <= r_checksum + r_data;
    end
  end

  assign o_checksum = r_checksum;
`endif

endmodule

// File: tb/tb_dma_byte_writer.sv
// Randomized self-checking bench for dma_byte_writer against a transfer-level
// model (expected word list, FIFO occupancy from byte/write counts).
module tb_dma_byte_writer;

  localparam int DEPTH = 4;
  localparam int LEN_W = 16;

  logic             CLK = 1'b0;
  logic             RESETn;
  logic [15:0]      i_RCC_DMA_ADDR_HIGH;
  logic [15:0]      i_RCC_DMA_ADDR_LOW;
  logic [LEN_W-1:0] i_RCC_DMA_LEN;
  logic             Write_Request;
  logic [7:0]       i_byte;
  logic             i_byte_valid;
  logic             o_byte_ready;
  logic             DMA_WRITE;
  logic [31:0]      DMA_WRITE_addr;
  logic [31:0]      DMA_WRITE_data;
  logic             i_DMA_WRITE_done;
  logic             o_busy;
  logic             o_done;
`ifdef DMA_BYTE_WRITER_CHECKSUM_EN
  logic [31:0]      o_checksum;
`endif

  int assertCount = 0;
  int failCount   = 0;
  int stallSeen   = 0;
  logic [7:0] fixedBytes[$];

  always #5 CLK = ~CLK;

  dma_byte_writer #(
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (LEN_W)
  ) dut (
    .CLK                 (CLK),
    .RESETn              (RESETn),
    .i_RCC_DMA_ADDR_HIGH (i_RCC_DMA_ADDR_HIGH),
    .i_RCC_DMA_ADDR_LOW  (i_RCC_DMA_ADDR_LOW),
    .i_RCC_DMA_LEN       (i_RCC_DMA_LEN),
    .Write_Request       (Write_Request),
    .i_byte              (i_byte),
    .i_byte_valid        (i_byte_valid),
    .o_byte_ready        (o_byte_ready),
    .DMA_WRITE           (DMA_WRITE),
    .DMA_WRITE_addr      (DMA_WRITE_addr),
    .DMA_WRITE_data      (DMA_WRITE_data),
    .i_DMA_WRITE_done    (i_DMA_WRITE_done),
    .o_busy              (o_busy),
    .o_done              (o_done)
`ifdef DMA_BYTE_WRITER_CHECKSUM_EN
    ,
    .o_checksum          (o_checksum)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_dma_write"}, 32'(DMA_WRITE), 32'd0);
    checkOutput({tag, "_addr"}, DMA_WRITE_addr, 32'd0);
    checkOutput({tag, "_data"}, DMA_WRITE_data, 32'd0);
    checkOutput({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
    checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(o_done), 32'd0);
`ifdef DMA_BYTE_WRITER_CHECKSUM_EN
    checkOutput({tag, "_checksum"}, o_checksum, 32'd0);
`endif
  endtask

  // Runs one transfer; abortAfter >= 0 stops once that many writes have completed.
  task automatic applyStimulus(input logic [31:0] base, input int len, input int minDelay,
                               input int maxDelay, input int validPct, input int abortAfter);
    logic [7:0]  bytes[$];
    logic [31:0] sum;
    logic [31:0] lastAddr;
    logic [31:0] lastData;
    int          acc;
    int          wr;
    int          cycle;
    int          finishCycle;
    int          countdown;
    bit          outstanding;
    bit          doneNow;
    bit          expReady;
    bit          expWrite;
    bit          aborted;

    for (int i = 0; i < len * 4 + 4; i++) begin
      bytes.push_back((i < fixedBytes.size()) ? fixedBytes[i] : 8'($urandom));
    end
    fixedBytes.delete();
    sum = 32'd0;
    for (int i = 0; i < len; i++) begin
      sum = sum + {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
    end

    acc = 0; wr = 0; cycle = 0; countdown = 0;
    outstanding = 0; doneNow = 0; aborted = 0;
    lastAddr = 32'd0; lastData = 32'd0;
    finishCycle = (len == 0) ? 1 : -1;

    @(posedge CLK); #1;
    i_RCC_DMA_ADDR_HIGH = base[31:16];
    i_RCC_DMA_ADDR_LOW  = base[15:0];
    i_RCC_DMA_LEN       = LEN_W'(len);
    Write_Request       = 1'b1;
    i_byte_valid        = 1'b0;
    i_DMA_WRITE_done    = 1'b0;
    @(posedge CLK); #1;

    while (1) begin
      cycle++;
      Write_Request = (finishCycle < 0 || cycle <= finishCycle) && ($urandom_range(0, 19) == 0);
      i_RCC_DMA_LEN = LEN_W'($urandom_range(0, 9));
      if (outstanding) begin
        if (countdown == 0) begin
          i_DMA_WRITE_done = 1'b1;
          doneNow          = 1;
        end else begin
          i_DMA_WRITE_done = 1'b0;
          countdown--;
        end
      end else begin
        i_DMA_WRITE_done = ($urandom_range(0, 9) == 0);
      end
      i_byte_valid = (acc < bytes.size()) && ($urandom_range(0, 99) < validPct);
      i_byte       = (acc < bytes.size()) ? bytes[acc] : 8'h00;

      @(negedge CLK);
      expReady = (acc < 4 * len) && !((acc % 4 == 3) && (acc / 4 - wr == DEPTH));
      if ((acc < 4 * len) && (acc % 4 == 3) && (acc / 4 - wr == DEPTH)) stallSeen++;
      checkOutput("byte_ready", 32'(o_byte_ready), 32'(expReady));
      expWrite = !outstanding && (wr < len) && (acc / 4 > wr);
      checkOutput("dma_write", 32'(DMA_WRITE), 32'(expWrite));
      if (outstanding) begin
        checkOutput("addr_hold", DMA_WRITE_addr, lastAddr);
        checkOutput("data_hold", DMA_WRITE_data, lastData);
      end
      if (DMA_WRITE && wr < len) begin
        lastAddr = base + 32'(4 * wr);
        lastData = {bytes[4*wr+3], bytes[4*wr+2], bytes[4*wr+1], bytes[4*wr]};
        checkOutput("write_addr", DMA_WRITE_addr, lastAddr);
        checkOutput("write_data", DMA_WRITE_data, lastData);
        wr++;
        outstanding = 1;
        countdown   = $urandom_range(maxDelay, minDelay);
      end
      if (i_byte_valid && o_byte_ready) acc++;
      checkOutput("o_done", 32'(o_done), 32'(cycle == finishCycle));
      checkOutput("o_busy", 32'(o_busy), 32'(finishCycle < 0 || cycle <= finishCycle));
`ifdef DMA_BYTE_WRITER_CHECKSUM_EN
      if (cycle == finishCycle) checkOutput("checksum", o_checksum, sum);
`endif
      if (doneNow) begin
        doneNow     = 0;
        outstanding = 0;
        if (wr == len) finishCycle = cycle + 1;
      end
      if (finishCycle >= 0 && cycle == finishCycle + 1) break;
      if (abortAfter >= 0 && wr == abortAfter && !outstanding) begin
        aborted = 1;
        break;
      end
      if (cycle > 4000) begin
        checkOutput("timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge CLK); #1;
    end

    if (!aborted) begin
      checkOutput("bytes_accepted", 32'(acc), 32'(4 * len));
      checkOutput("write_count", 32'(wr), 32'(len));
    end
    Write_Request    = 1'b0;
    i_byte_valid     = 1'b0;
    i_DMA_WRITE_done = 1'b0;
  endtask

  initial begin
    RESETn              = 1'b0;
    i_RCC_DMA_ADDR_HIGH = 16'h0;
    i_RCC_DMA_ADDR_LOW  = 16'h0;
    i_RCC_DMA_LEN       = '0;
    Write_Request       = 1'b0;
    i_byte              = 8'h0;
    i_byte_valid        = 1'b0;
    i_DMA_WRITE_done    = 1'b0;
    #12;
    checkIdleOutputs("reset");
    @(negedge CLK);
    RESETn = 1'b1;

    $display("[TB] single word");
    fixedBytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(32'h2000_0010, 1, 0, 3, 100, -1);

    $display("[TB] back-pressure");
    stallSeen = 0;
    applyStimulus(32'h1000_0000, 8, 10, 10, 100, -1);
    checkOutput("stall_seen", 32'(stallSeen > 0), 32'd1);

    $display("[TB] address wrap");
    applyStimulus(32'hFFFF_FFFC, 2, 0, 2, 100, -1);

    $display("[TB] zero length");
    applyStimulus(32'h5000_0000, 0, 0, 0, 100, -1);

    $display("[TB] checksum words");
    fixedBytes = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    applyStimulus(32'h6000_0000, 2, 0, 3, 100, -1);

    $display("[TB] random transfers");
    repeat (6) begin
      applyStimulus($urandom, $urandom_range(1, 6), 0, $urandom_range(0, 5),
                    $urandom_range(30, 100), -1);
    end

    $display("[TB] reset mid-transfer");
    applyStimulus(32'h3000_0000, 4, 1, 3, 100, 2);
    #2;
    RESETn = 1'b0;
    #1;
    checkIdleOutputs("abort");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
    applyStimulus(32'h4000_0000, 3, 0, 2, 80, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
